// File: rtl/sram_like_arbiter_if.sv
// ============================================================================
// Module   : sram_like_arbiter_if
// Purpose  : sram-like request/response bundle (req / addr_ok / data_ok).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// Module   : sram_like_arbiter
// Purpose  : Merges inst and data sram-like masters onto one slave port,
//            routing each data_ok back in issue order via an owner queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_like_arbiter #(
    parameter int OT_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  wire                clk,
    input  wire                reset,
    sram_like_arbiter_if.slave  inst,
    sram_like_arbiter_if.slave  data,
    sram_like_arbiter_if.master slave,
    output logic               arb_err
);

    localparam int c_ptr_w = $clog2(OT_DEPTH);
    localparam int c_st_w  = $clog2(STARVE_MAX) + 1;
    localparam logic [c_ptr_w:0]  c_depth      = (c_ptr_w+1)'(OT_DEPTH);
    localparam logic [c_st_w-1:0] c_starve_max = c_st_w'(STARVE_MAX);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    logic [OT_DEPTH-1:0] r_q;
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;
    logic [c_ptr_w:0]    r_cnt;
    logic                r_locked;
    owner_e              r_lock_owner;
    logic [c_st_w-1:0]   r_starve;
    logic                r_arb_err;

    owner_e w_owner;
    logic   w_gnt;
    logic   w_full;
    logic   w_own_req;
    logic   w_slave_req;
    logic   w_accept;
    logic   w_pop;
    logic   w_head;

    always_comb begin
        w_gnt   = 1'b1;
        w_owner = OWN_INST;
        if (r_locked)
            w_owner = r_lock_owner;
        else if (r_starve == c_starve_max && inst.req)
            w_owner = OWN_INST;
        else if (data.req)
            w_owner = OWN_DATA;
        else if (inst.req)
            w_owner = OWN_INST;
        else
            w_gnt = 1'b0;
    end

    assign w_full      = (r_cnt == c_depth);
    assign w_own_req   = (w_owner == OWN_DATA) ? data.req : inst.req;
    assign w_slave_req = w_gnt & w_own_req & ~w_full & ~reset;
    assign w_accept    = w_slave_req & slave.addr_ok;
    // Responses with nothing outstanding are flagged, never forwarded.
    assign w_pop       = slave.data_ok & (r_cnt != '0) & ~reset;
    assign w_head      = r_q[r_rptr];

    always_comb begin
        slave.req   = w_slave_req;
        slave.wr    = 1'b0;
        slave.size  = 2'd0;
        slave.addr  = 32'd0;
        slave.wstrb = 4'd0;
        slave.wdata = 32'd0;
        if (w_gnt) begin
            if (w_owner == OWN_DATA) begin
                slave.wr    = data.wr;
                slave.size  = data.size;
                slave.addr  = data.addr;
                slave.wstrb = data.wstrb;
                slave.wdata = data.wdata;
            end else begin
                slave.wr    = inst.wr;
                slave.size  = inst.size;
                slave.addr  = inst.addr;
                slave.wstrb = inst.wstrb;
                slave.wdata = inst.wdata;
            end
        end
    end

    assign inst.addr_ok = w_slave_req & slave.addr_ok & (w_owner == OWN_INST);
    assign data.addr_ok = w_slave_req & slave.addr_ok & (w_owner == OWN_DATA);
    assign inst.data_ok = w_pop & ~w_head;
    assign data.data_ok = w_pop & w_head;
    assign inst.rdata   = (w_pop & ~w_head) ? slave.rdata : 32'd0;
    assign data.rdata   = (w_pop & w_head)  ? slave.rdata : 32'd0;
    assign arb_err      = r_arb_err & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q          <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_cnt        <= '0;
            r_locked     <= 1'b0;
            r_lock_owner <= OWN_INST;
            r_starve     <= '0;
            r_arb_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_q[r_wptr] <= w_owner;
                r_wptr      <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;

            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            if (slave.data_ok && r_cnt == '0)
                r_arb_err <= 1'b1;

            // Hold the grant until the issued request is taken by the slave.
            if (w_accept)
                r_locked <= 1'b0;
            else if (w_slave_req) begin
                r_locked     <= 1'b1;
                r_lock_owner <= w_owner;
            end

            if ((w_accept && w_owner == OWN_INST) || !inst.req)
                r_starve <= '0;
            else if (w_accept && w_owner == OWN_DATA && r_starve != c_starve_max)
                r_starve <= r_starve + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// Module   : tb_sram_like_arbiter
// Purpose  : Directed stimulus with a queue-based reference model and checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

    localparam int OT_DEPTH   = 4;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    sram_like_arbiter_if inst_if ();
    sram_like_arbiter_if data_if ();
    sram_like_arbiter_if slv_if ();

    sram_like_arbiter #(
        .OT_DEPTH   (OT_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .inst    (inst_if),
        .data    (data_if),
        .slave   (slv_if),
        .arb_err (arb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner ids kept in a plain queue, oldest first.
    bit mq[$];
    bit m_locked, m_lock_owner, m_err;
    int m_starve;

    always @(negedge clk) begin : cmp
        bit gv, go, esreq, pop, head, acc;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_size;
        logic        e_wr;
        if (reset) begin
            chk("m_rst_sreq",  slv_if.req, 0);
            chk("m_rst_iaok",  inst_if.addr_ok, 0);
            chk("m_rst_daok",  data_if.addr_ok, 0);
            chk("m_rst_idok",  inst_if.data_ok, 0);
            chk("m_rst_ddok",  data_if.data_ok, 0);
            chk("m_rst_irdat", inst_if.rdata, 0);
            chk("m_rst_drdat", data_if.rdata, 0);
            chk("m_rst_err",   arb_err, 0);
            mq.delete();
            m_locked = 0; m_lock_owner = 0; m_starve = 0; m_err = 0;
        end else begin
            gv = 1; go = 0;
            if (m_locked) go = m_lock_owner;
            else if (m_starve == STARVE_MAX && inst_if.req) go = 0;
            else if (data_if.req) go = 1;
            else if (inst_if.req) go = 0;
            else gv = 0;
            esreq = gv && (go ? data_if.req : inst_if.req) && (mq.size() < OT_DEPTH);
            e_wr = 0; e_size = 0; e_addr = 0; e_wstrb = 0; e_wdata = 0;
            if (gv) begin
                e_wr    = go ? data_if.wr    : inst_if.wr;
                e_size  = go ? data_if.size  : inst_if.size;
                e_addr  = go ? data_if.addr  : inst_if.addr;
                e_wstrb = go ? data_if.wstrb : inst_if.wstrb;
                e_wdata = go ? data_if.wdata : inst_if.wdata;
            end
            acc  = esreq && slv_if.addr_ok;
            pop  = slv_if.data_ok && mq.size() > 0;
            head = pop ? mq[0] : 1'b0;

            chk("m_sreq",  slv_if.req, esreq);
            chk("m_swr",   slv_if.wr, e_wr);
            chk("m_ssize", slv_if.size, e_size);
            chk("m_saddr", slv_if.addr, e_addr);
            chk("m_sstrb", slv_if.wstrb, e_wstrb);
            chk("m_swdat", slv_if.wdata, e_wdata);
            chk("m_iaok",  inst_if.addr_ok, acc && !go);
            chk("m_daok",  data_if.addr_ok, acc && go);
            chk("m_idok",  inst_if.data_ok, pop && !head);
            chk("m_ddok",  data_if.data_ok, pop && head);
            chk("m_irdat", inst_if.rdata, (pop && !head) ? slv_if.rdata : 32'd0);
            chk("m_drdat", data_if.rdata, (pop && head) ? slv_if.rdata : 32'd0);
            chk("m_err",   arb_err, m_err);

            if (slv_if.data_ok && mq.size() == 0) m_err = 1;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(go);
            if (acc) m_locked = 0;
            else if (esreq) begin m_locked = 1; m_lock_owner = go; end
            if ((acc && !go) || !inst_if.req) m_starve = 0;
            else if (acc && go && m_starve < STARVE_MAX) m_starve++;
        end
    end

    task automatic idle();
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0;
        inst_if.wstrb = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0;
        data_if.wstrb = 0; data_if.wdata = 0;
        slv_if.addr_ok = 0; slv_if.data_ok = 0; slv_if.rdata = 0;
    endtask

    task automatic set_inst(input logic r, input logic w, input logic [31:0] a);
        inst_if.req = r; inst_if.wr = w; inst_if.size = 2'd2; inst_if.addr = a;
        inst_if.wstrb = w ? 4'hF : 4'h0; inst_if.wdata = a ^ 32'h5A5A0000;
    endtask

    task automatic set_data(input logic r, input logic w, input logic [31:0] a);
        data_if.req = r; data_if.wr = w; data_if.size = 2'd2; data_if.addr = a;
        data_if.wstrb = w ? 4'hF : 4'h0; data_if.wdata = a ^ 32'hA5A50000;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        set_data(1, 0, 32'h0000_0040);
        slv_if.addr_ok = 1;
        neg(); chk("rst_sreq", slv_if.req, 0); chk("rst_err", arb_err, 0);
        cyc(); idle();
        neg(); chk("rst_sreq2", slv_if.req, 0);
        cyc(); reset = 0;

        // single inst read
        set_inst(1, 0, 32'h1c00_0000); slv_if.addr_ok = 1;
        neg(); chk("s1_iaok", inst_if.addr_ok, 1); chk("s1_saddr", slv_if.addr, 32'h1c00_0000);
        chk("s1_daok", data_if.addr_ok, 0);
        cyc(); idle();
        neg(); chk("s1_iaok_pulse", inst_if.addr_ok, 0);
        cyc(); cyc();
        slv_if.data_ok = 1; slv_if.rdata = 32'hDEAD_BEEF;
        neg(); chk("s1_idok", inst_if.data_ok, 1); chk("s1_irdat", inst_if.rdata, 32'hDEAD_BEEF);
        chk("s1_ddok", data_if.data_ok, 0); chk("s1_drdat", data_if.rdata, 0);
        cyc(); idle();
        neg(); chk("s1_idok_pulse", inst_if.data_ok, 0);
        cyc();

        // simultaneous requests: data first
        set_inst(1, 0, 32'h0000_2000); set_data(1, 1, 32'h0000_1000); slv_if.addr_ok = 1;
        neg(); chk("s2_daok", data_if.addr_ok, 1); chk("s2_iaok0", inst_if.addr_ok, 0);
        chk("s2_saddr0", slv_if.addr, 32'h0000_1000); chk("s2_swr", slv_if.wr, 1);
        chk("s2_sstrb", slv_if.wstrb, 4'hF);
        cyc(); data_if.req = 0;
        neg(); chk("s2_iaok1", inst_if.addr_ok, 1); chk("s2_saddr1", slv_if.addr, 32'h0000_2000);
        cyc(); idle(); cyc(); cyc();
        slv_if.data_ok = 1; slv_if.rdata = 32'h11;
        neg(); chk("s2_ddok", data_if.data_ok, 1); chk("s2_drdat", data_if.rdata, 32'h11);
        chk("s2_idok0", inst_if.data_ok, 0);
        cyc(); slv_if.rdata = 32'h22;
        neg(); chk("s2_idok", inst_if.data_ok, 1); chk("s2_irdat", inst_if.rdata, 32'h22);
        chk("s2_drdat0", data_if.rdata, 0);
        cyc(); idle(); cyc();

        // lock held across slave back-pressure
        set_inst(1, 0, 32'h0000_3000);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_data(1, 0, 32'h0000_4000);
            slv_if.addr_ok = (c == 3);
            neg(); chk("s3_saddr", slv_if.addr, 32'h0000_3000); chk("s3_sreq", slv_if.req, 1);
            chk("s3_iaok", inst_if.addr_ok, c == 3); chk("s3_daok", data_if.addr_ok, 0);
            cyc();
        end
        inst_if.req = 0;
        neg(); chk("s3_daok4", data_if.addr_ok, 1); chk("s3_saddr4", slv_if.addr, 32'h0000_4000);
        cyc(); idle(); slv_if.data_ok = 1; slv_if.rdata = 32'h33;
        neg(); chk("s3_idok", inst_if.data_ok, 1);
        cyc(); slv_if.rdata = 32'h44;
        neg(); chk("s3_ddok", data_if.data_ok, 1); chk("s3_drdat", data_if.rdata, 32'h44);
        cyc(); idle(); cyc();

        // owner queue full
        slv_if.addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            set_data(1, 0, 32'h100 + 32'(4 * i));
            neg(); chk("s4_daok", data_if.addr_ok, 1);
            cyc();
        end
        set_data(1, 0, 32'h200);
        neg(); chk("s4_full_sreq", slv_if.req, 0); chk("s4_full_daok", data_if.addr_ok, 0);
        cyc();
        neg(); chk("s4_full_sreq2", slv_if.req, 0);
        cyc(); slv_if.data_ok = 1; slv_if.rdata = 32'hA0;
        neg(); chk("s4_pop_ddok", data_if.data_ok, 1); chk("s4_pop_rdat", data_if.rdata, 32'hA0);
        chk("s4_pop_sreq", slv_if.req, 0);
        cyc(); slv_if.data_ok = 0;
        neg(); chk("s4_reen_sreq", slv_if.req, 1); chk("s4_reen_daok", data_if.addr_ok, 1);
        cyc(); idle();
        for (int i = 0; i < 4; i++) begin
            slv_if.data_ok = 1; slv_if.rdata = 32'(i);
            neg(); chk("s4_drain", data_if.data_ok, 1);
            cyc();
        end
        idle(); cyc();

        // starvation: 8 data grants, then inst forced through
        set_data(1, 0, 32'h500); set_inst(1, 0, 32'h600); slv_if.addr_ok = 1;
        for (int c = 0; c < 11; c++) begin
            slv_if.data_ok = (c != 0); slv_if.rdata = 32'(c);
            neg(); chk("s5_iaok", inst_if.addr_ok, c == 8); chk("s5_daok", data_if.addr_ok, c != 8);
            if (c > 0) chk("s5_idok", inst_if.data_ok, c == 9);
            if (c == 9) chk("s5_irdat", inst_if.rdata, 32'd9);
            cyc();
        end
        idle(); slv_if.data_ok = 1; slv_if.rdata = 32'hB;
        neg(); chk("s5_last_ddok", data_if.data_ok, 1); chk("s5_last_rdat", data_if.rdata, 32'hB);
        cyc(); idle(); cyc();

        // spurious response, then reset with requests outstanding
        slv_if.data_ok = 1; slv_if.rdata = 32'h55;
        neg(); chk("s6_idok", inst_if.data_ok, 0); chk("s6_ddok", data_if.data_ok, 0);
        chk("s6_err_pre", arb_err, 0);
        cyc(); idle();
        neg(); chk("s6_err", arb_err, 1);
        cyc();
        neg(); chk("s6_err_sticky", arb_err, 1);
        cyc(); set_inst(1, 0, 32'h700); slv_if.addr_ok = 1;
        neg(); chk("s6_iaok", inst_if.addr_ok, 1);
        cyc(); idle(); set_data(1, 0, 32'h704); slv_if.addr_ok = 1;
        neg(); chk("s6_daok", data_if.addr_ok, 1);
        cyc(); reset = 1; slv_if.data_ok = 1;
        neg(); chk("s6_rst_sreq", slv_if.req, 0); chk("s6_rst_err", arb_err, 0);
        chk("s6_rst_ddok", data_if.data_ok, 0);
        cyc(); reset = 0; idle(); slv_if.data_ok = 1;
        neg(); chk("s6_post_err", arb_err, 0); chk("s6_post_idok", inst_if.data_ok, 0);
        chk("s6_post_ddok", data_if.data_ok, 0);
        cyc(); idle();
        neg(); chk("s6_err_again", arb_err, 1);
        cyc();

        neg(); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
